// File: rtl/elastic_stage_register.sv
// Handshaked pipeline stage with a two-entry skid buffer, synchronous flush and
// a saturating stall-cycle counter. Backpressure comes only from registered state.
module elastic_stage_register #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_main;
    logic [WIDTH-1:0]      r_skid;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [1:0]            r_occupancy;
    logic [CNT_WIDTH-1:0]  r_stall;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_stalled;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      w_main_nxt;
    logic [WIDTH-1:0]      w_skid_nxt;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_stalled  = r_out_valid & ~out_ready;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // The skid word always follows the main word out.
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_occupancy <= w_state_nxt;
        end
    end

    // Flush does not clear the counter; a stalled flush cycle still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_stalled && (r_stall != {CNT_WIDTH{1'b1}})) begin
            r_stall <= r_stall + CNT_WIDTH'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_main;
    assign occupancy   = r_occupancy;
    assign stall_count = r_stall;

endmodule

// File: tb/tb_elastic_stage_register.sv
// Directed, table-driven bench for elastic_stage_register plus hand-written
// reset and stall-counter saturation sequences on a narrow-counter instance.
module tb_elastic_stage_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    logic        c2_flush, c2_in_valid, c2_out_ready;
    logic [7:0]  c2_in_data;
    logic        c2_in_ready, c2_out_valid;
    logic [7:0]  c2_out_data;
    logic [1:0]  c2_occupancy;
    logic [1:0]  c2_stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elastic_stage_register #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    elastic_stage_register #(.WIDTH(8), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .reset(reset), .flush(c2_flush),
        .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_data(c2_in_data),
        .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_data(c2_out_data),
        .occupancy(c2_occupancy), .stall_count(c2_stall_count)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_ov, input logic e_ir,
                                 input logic [31:0] e_od, input logic [1:0] e_occ,
                                 input logic [15:0] e_stall);
        check({tag, ".out_valid"},   32'(out_valid),   32'(e_ov));
        check({tag, ".in_ready"},    32'(in_ready),    32'(e_ir));
        check({tag, ".out_data"},    out_data,         e_od);
        check({tag, ".occupancy"},   32'(occupancy),   32'(e_occ));
        check({tag, ".stall_count"}, 32'(stall_count), 32'(e_stall));
    endtask

    // Drive one cycle of inputs, then sample the outputs 1 time unit after the edge.
    task automatic apply(input string tag, input vec_t v);
        flush     = v.fl;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
        check_outputs(tag, v.e_ov, v.e_ir, v.e_od, v.e_occ, v.e_stall);
    endtask

    initial begin
        vec_t v;

        //          fl    iv    id      rdy   ov    ir    od      occ   stall
        // Stream 1,2,3 at full rate, then drain
        vecs[0]  = '{1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1, 2'd1, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2, 2'd1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3, 2'd0, 16'd0};
        // Backpressure: A then B into skid, hold 3 cycles, FULL out_fire with C/D offered
        vecs[4]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 2'd1, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA, 2'd2, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA, 2'd2, 16'd2};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA, 2'd2, 16'd3};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA, 2'd2, 16'd4};
        vecs[9]  = '{1'b0, 1'b1, 32'hD, 1'b1, 1'b1, 1'b1, 32'hB, 2'd1, 16'd4};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 2'd0, 16'd4};
        // Flush while FULL with in_valid=1 and out_ready=1: both fires dropped
        vecs[11] = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5, 2'd1, 16'd4};
        vecs[12] = '{1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 1'b0, 32'h5, 2'd2, 16'd5};
        vecs[13] = '{1'b1, 1'b1, 32'h7, 1'b1, 1'b0, 1'b1, 32'h0, 2'd0, 16'd5};
        vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 2'd0, 16'd5};
        // Flush in ONE while stalled still counts; flush on EMPTY drops the offered word
        vecs[15] = '{1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 32'h8, 2'd1, 16'd5};
        vecs[16] = '{1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 16'd6};
        vecs[17] = '{1'b1, 1'b1, 32'h9, 1'b1, 1'b0, 1'b1, 32'h0, 2'd0, 16'd6};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c2_flush = 1'b0; c2_in_valid = 1'b0; c2_in_data = '0; c2_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b1, 32'h0, 2'd0, 16'd0);
        check("c2_reset.stall_count", 32'(c2_stall_count), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while FULL with stall_count=5
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("rst2", 1'b0, 1'b1, 32'h0, 2'd0, 16'd0);
        v = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1, 16'd0};
        apply("fill0", v);
        v = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h11, 2'd2, 16'd1};
        apply("fill1", v);
        for (int k = 0; k < 4; k++) begin
            v = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11, 2'd2, 16'(k + 2)};
            apply($sformatf("hold%0d", k), v);
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_full", 1'b0, 1'b1, 32'h0, 2'd0, 16'd0);
        reset = 1'b0; in_valid = 1'b0;

        // Narrow counter saturates at 3 without wrapping
        c2_in_valid = 1'b1; c2_in_data = 8'h5A; c2_out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("c2_load.out_valid", 32'(c2_out_valid), 32'd1);
        check("c2_load.out_data", 32'(c2_out_data), 32'h5A);
        check("c2_load.stall_count", 32'(c2_stall_count), 32'd0);
        c2_in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("c2_sat%0d.stall_count", k), 32'(c2_stall_count),
                  (k < 3) ? 32'(k + 1) : 32'd3);
        end
        check("c2_sat.occupancy", 32'(c2_occupancy), 32'd1);
        check("c2_sat.in_ready", 32'(c2_in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_stage_register.md
# elastic_stage_register

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. Decouples upstream and downstream stall logic in the datapath pipeline. Provides full throughput, registered backpressure, a synchronous flush for branch/exception squash, and a saturating stall-cycle counter for performance monitoring. It is the handshaked successor to the plain load/reset stage register and sits between any two pipeline stages.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1)
- CNT_WIDTH, 16, stall counter width in bits (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  squash all held entries (synchronous)
- in_valid  input  1  upstream has a word
- in_ready  output  1  stage can accept a word; registered, no combinational path from out_ready
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage presents a word
- out_ready  input  1  downstream accepts the word
- out_data  output  WIDTH  payload presented downstream
- occupancy  output  2  held entries (0, 1 or 2)
- stall_count  output  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. A word transfers only on a fire cycle.
- Storage: main register (drives out_data) and skid register. State is EMPTY, ONE or FULL.
- out_valid = (state != EMPTY); in_ready = (state != FULL); occupancy = 0/1/2 for EMPTY/ONE/FULL.
- EMPTY: in_fire → ONE, main ← in_data.
- ONE: in_fire & out_fire → ONE, main ← in_data. in_fire only → FULL, skid ← in_data. out_fire only → EMPTY. Neither → hold.
- FULL: in_ready=0. out_fire → ONE, main ← skid. Otherwise hold.
- Ordering: strict FIFO. The skid word always leaves after the main word.
- out_data when out_valid=0 holds the last main value. Downstream treats it as don't-care.
- Flush: state → EMPTY, main and skid ← 0. Any in_fire or out_fire in the flush cycle is ignored and the word is dropped. Upstream squashes in the same cycle.
- stall_count: +1 per cycle with out_valid & !out_ready. Saturates at 2^CNT_WIDTH−1 with no wrap. Cleared by reset only; flush does not clear it. A flush cycle with out_valid & !out_ready still counts.
- Priority: reset > flush > handshake logic.

## Timing
- Reset values: state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, out_data=0, occupancy=0, stall_count=0.
- Latency: a word accepted on edge N appears on out_data with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: out_ready dropping in ONE still admits one more word into skid. in_ready falls the cycle after the skid fills. in_ready rises the cycle after the first out_fire from FULL.
- No combinational path from in_valid/in_data to out_* or from out_ready to in_ready.
- Reset or flush asserted mid-operation takes effect at the next edge regardless of the current state.

## Test plan
- Reset then stream 0x1,0x2,0x3 with out_ready=1 → out_data 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after acceptance; occupancy stays 1; stall_count=0.
- Accept 0xA, drop out_ready, offer 0xB → state FULL, in_ready=0 next cycle, occupancy=2. Hold 3 cycles, then raise out_ready → 0xA then 0xB delivered in order; stall_count=4.
- FULL with out_fire and in_valid in the same cycle → in_ready=0 blocks the input; next cycle ONE with main=0xB, in_ready=1.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0; offered word not delivered; stall_count unchanged.
- CNT_WIDTH=2, hold out_valid=1 and out_ready=0 for 6 cycles → stall_count 1,2,3,3,3,3.
- Assert reset while FULL with stall_count=5 → next cycle all outputs at reset values.
